// File: rtl/dispatch_branch_mem_pkg.sv
// Shared widths, memory geometry and control-field bit positions for the
// dispatch / branch / data-memory slice.
package dispatch_branch_mem_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int TAG_WIDTH  = 4;
  localparam int CTRL_WIDTH = 6;
  localparam int FUNC_WIDTH = 3;
  localparam int MEM_DEPTH  = 1024;

  // Bit positions inside the 6-bit decoded control field.
  localparam int CTRL_LOAD   = 5;
  localparam int CTRL_STORE  = 4;
  localparam int CTRL_RTYPE  = 3;
  localparam int CTRL_BRANCH = 2;
  localparam int CTRL_JUMP   = 1;
  localparam int CTRL_HALT   = 0;

endpackage

// File: rtl/branch_resolve.sv
// Branch comparator and target adder; purely combinational, no reset.
module branch_resolve
  import dispatch_branch_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] br_rs,
  input  logic [DATA_WIDTH-1:0] br_rt,
  input  logic [DATA_WIDTH-1:0] br_pc,
  input  logic [DATA_WIDTH-1:0] br_imm,
  input  logic                  br_issued,
  output logic                  br_taken,
  output logic [DATA_WIDTH-1:0] br_target
);

  // Equality-taken decision; target wraps modulo 2^DATA_WIDTH.
  always_comb begin
    br_taken  = 1'b0;
    br_target = br_pc + br_imm;
    if (br_issued && (br_rs == br_rt)) begin
      br_taken = 1'b1;
    end else begin
      br_taken = 1'b0;
    end
  end

endmodule

// File: rtl/data_mem_2w.sv
// Data memory with two write ports (port 2 wins on collision), one
// asynchronous read port, halt write-suppression and whole-array reset.
module data_mem_2w
  import dispatch_branch_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ld_addr,
  input  logic                  is_load,
  input  logic [1:0]            mem_write,
  input  logic [DATA_WIDTH-1:0] st_data1,
  input  logic [DATA_WIDTH-1:0] st_data2,
  input  logic [DATA_WIDTH-1:0] st_addr1,
  input  logic [DATA_WIDTH-1:0] st_addr2,
  input  logic                  hlt,
  output logic [DATA_WIDTH-1:0] ld_data
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];
  logic                  unused_addr_bits_s;

  // Upper address bits are deliberately dropped so addresses wrap.
  assign unused_addr_bits_s = ^{ld_addr[DATA_WIDTH-1:AW],
                                st_addr1[DATA_WIDTH-1:AW],
                                st_addr2[DATA_WIDTH-1:AW]};

  // Writes: port 1 first, port 2 after so the younger store wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (!hlt) begin
      if (mem_write[0]) begin
        mem_r[st_addr1[AW-1:0]] <= st_data1;
      end
      if (mem_write[1]) begin
        mem_r[st_addr2[AW-1:0]] <= st_data2;
      end
    end
  end

  // Asynchronous read, forced to zero when no load is in progress.
  always_comb begin
    ld_data = '0;
    if (is_load) begin
      ld_data = mem_r[ld_addr[AW-1:0]];
    end else begin
      ld_data = '0;
    end
  end

endmodule

// File: rtl/dispatch_reg.sv
// Dispatch pipeline register: flush clears (ctrl=0 is a bubble), disp_write
// loads, otherwise hold. Reset clears immediately.
module dispatch_reg
  import dispatch_branch_mem_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_write,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // Pipeline register with flush priority over load, async clear on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= '0;
    end else if (flush) begin
      q_r <= '0;
    end else if (disp_write) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/dispatch_branch_mem.sv
// Top of the slice: dispatch pipeline register, branch resolution and the
// two-write-port data memory side by side.
module dispatch_branch_mem
  import dispatch_branch_mem_pkg::*;
#(
  parameter int DATA_WIDTH = dispatch_branch_mem_pkg::DATA_WIDTH,
  parameter int MEM_DEPTH  = dispatch_branch_mem_pkg::MEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  // dispatch inputs
  input  logic [TAG_WIDTH-1:0]  tag_in1,
  input  logic [TAG_WIDTH-1:0]  tag_in2,
  input  logic [TAG_WIDTH-1:0]  tag_in3,
  input  logic [TAG_WIDTH-1:0]  tag_in4,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic [DATA_WIDTH-1:0] data_in4,
  input  logic [DATA_WIDTH-1:0] imm_in1,
  input  logic [DATA_WIDTH-1:0] imm_in2,
  input  logic [CTRL_WIDTH-1:0] ctrl_in1,
  input  logic [CTRL_WIDTH-1:0] ctrl_in2,
  input  logic [FUNC_WIDTH-1:0] func_in1,
  input  logic [FUNC_WIDTH-1:0] func_in2,
  input  logic [TAG_WIDTH-1:0]  rob_in1,
  input  logic [TAG_WIDTH-1:0]  rob_in2,
  input  logic                  spec_in1,
  input  logic                  spec_in2,
  input  logic [DATA_WIDTH-1:0] pc2_in,
  input  logic                  npc_sel_in,
  input  logic                  flush,
  input  logic                  disp_write,
  // dispatch outputs
  output logic [TAG_WIDTH-1:0]  tag_out1,
  output logic [TAG_WIDTH-1:0]  tag_out2,
  output logic [TAG_WIDTH-1:0]  tag_out3,
  output logic [TAG_WIDTH-1:0]  tag_out4,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic [DATA_WIDTH-1:0] data_out2,
  output logic [DATA_WIDTH-1:0] data_out3,
  output logic [DATA_WIDTH-1:0] data_out4,
  output logic [DATA_WIDTH-1:0] imm_out1,
  output logic [DATA_WIDTH-1:0] imm_out2,
  output logic [CTRL_WIDTH-1:0] ctrl_out1,
  output logic [CTRL_WIDTH-1:0] ctrl_out2,
  output logic [FUNC_WIDTH-1:0] func_out1,
  output logic [FUNC_WIDTH-1:0] func_out2,
  output logic [TAG_WIDTH-1:0]  rob_out1,
  output logic [TAG_WIDTH-1:0]  rob_out2,
  output logic                  spec_out1,
  output logic                  spec_out2,
  output logic [DATA_WIDTH-1:0] pc2_out,
  output logic                  npc_sel_out,
  // branch
  input  logic [DATA_WIDTH-1:0] br_rs,
  input  logic [DATA_WIDTH-1:0] br_rt,
  input  logic [DATA_WIDTH-1:0] br_pc,
  input  logic [DATA_WIDTH-1:0] br_imm,
  input  logic                  br_issued,
  output logic                  br_taken,
  output logic [DATA_WIDTH-1:0] br_target,
  // memory
  input  logic [DATA_WIDTH-1:0] ld_addr,
  input  logic                  is_load,
  input  logic [1:0]            mem_write,
  input  logic [DATA_WIDTH-1:0] st_data1,
  input  logic [DATA_WIDTH-1:0] st_data2,
  input  logic [DATA_WIDTH-1:0] st_addr1,
  input  logic [DATA_WIDTH-1:0] st_addr2,
  input  logic                  hlt,
  output logic [DATA_WIDTH-1:0] ld_data
);

  // Every dispatch field packed into one vector so a single register holds it.
  localparam int DISP_W = 7 * DATA_WIDTH + 6 * TAG_WIDTH + 2 * CTRL_WIDTH
                        + 2 * FUNC_WIDTH + 3;

  logic [DISP_W-1:0] disp_d_s;
  logic [DISP_W-1:0] disp_q_s;

  assign disp_d_s = {tag_in1, tag_in2, tag_in3, tag_in4,
                     data_in1, data_in2, data_in3, data_in4,
                     imm_in1, imm_in2, ctrl_in1, ctrl_in2,
                     func_in1, func_in2, rob_in1, rob_in2,
                     spec_in1, spec_in2, pc2_in, npc_sel_in};

  assign {tag_out1, tag_out2, tag_out3, tag_out4,
          data_out1, data_out2, data_out3, data_out4,
          imm_out1, imm_out2, ctrl_out1, ctrl_out2,
          func_out1, func_out2, rob_out1, rob_out2,
          spec_out1, spec_out2, pc2_out, npc_sel_out} = disp_q_s;

  dispatch_reg #(
    .WIDTH(DISP_W)
  ) u_dispatch_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .disp_write(disp_write),
    .d         (disp_d_s),
    .q         (disp_q_s)
  );

  branch_resolve #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_branch_resolve (
    .br_rs    (br_rs),
    .br_rt    (br_rt),
    .br_pc    (br_pc),
    .br_imm   (br_imm),
    .br_issued(br_issued),
    .br_taken (br_taken),
    .br_target(br_target)
  );

  data_mem_2w #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_data_mem_2w (
    .clk      (clk),
    .rst      (rst),
    .ld_addr  (ld_addr),
    .is_load  (is_load),
    .mem_write(mem_write),
    .st_data1 (st_data1),
    .st_data2 (st_data2),
    .st_addr1 (st_addr1),
    .st_addr2 (st_addr2),
    .hlt      (hlt),
    .ld_data  (ld_data)
  );

endmodule

// File: tb/tb_dispatch_branch_mem.sv
// Bench for dispatch_branch_mem: directed vectors with literal expectations,
// plus a behavioural model compared against the DUT on every falling edge.
module tb_dispatch_branch_mem;

  logic        clk;
  logic        rst;
  logic [3:0]  tag_in1, tag_in2, tag_in3, tag_in4;
  logic [15:0] data_in1, data_in2, data_in3, data_in4;
  logic [15:0] imm_in1, imm_in2;
  logic [5:0]  ctrl_in1, ctrl_in2;
  logic [2:0]  func_in1, func_in2;
  logic [3:0]  rob_in1, rob_in2;
  logic        spec_in1, spec_in2;
  logic [15:0] pc2_in;
  logic        npc_sel_in;
  logic        flush, disp_write;
  logic [3:0]  tag_out1, tag_out2, tag_out3, tag_out4;
  logic [15:0] data_out1, data_out2, data_out3, data_out4;
  logic [15:0] imm_out1, imm_out2;
  logic [5:0]  ctrl_out1, ctrl_out2;
  logic [2:0]  func_out1, func_out2;
  logic [3:0]  rob_out1, rob_out2;
  logic        spec_out1, spec_out2;
  logic [15:0] pc2_out;
  logic        npc_sel_out;
  logic [15:0] br_rs, br_rt, br_pc, br_imm;
  logic        br_issued, br_taken;
  logic [15:0] br_target;
  logic [15:0] ld_addr;
  logic        is_load;
  logic [1:0]  mem_write;
  logic [15:0] st_data1, st_data2, st_addr1, st_addr2;
  logic        hlt;
  logic [15:0] ld_data;

  int n_cmp = 0;
  int n_bad = 0;

  dispatch_branch_mem dut (
    .clk(clk), .rst(rst),
    .tag_in1(tag_in1), .tag_in2(tag_in2), .tag_in3(tag_in3), .tag_in4(tag_in4),
    .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3), .data_in4(data_in4),
    .imm_in1(imm_in1), .imm_in2(imm_in2), .ctrl_in1(ctrl_in1), .ctrl_in2(ctrl_in2),
    .func_in1(func_in1), .func_in2(func_in2), .rob_in1(rob_in1), .rob_in2(rob_in2),
    .spec_in1(spec_in1), .spec_in2(spec_in2), .pc2_in(pc2_in), .npc_sel_in(npc_sel_in),
    .flush(flush), .disp_write(disp_write),
    .tag_out1(tag_out1), .tag_out2(tag_out2), .tag_out3(tag_out3), .tag_out4(tag_out4),
    .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3), .data_out4(data_out4),
    .imm_out1(imm_out1), .imm_out2(imm_out2), .ctrl_out1(ctrl_out1), .ctrl_out2(ctrl_out2),
    .func_out1(func_out1), .func_out2(func_out2), .rob_out1(rob_out1), .rob_out2(rob_out2),
    .spec_out1(spec_out1), .spec_out2(spec_out2), .pc2_out(pc2_out), .npc_sel_out(npc_sel_out),
    .br_rs(br_rs), .br_rt(br_rt), .br_pc(br_pc), .br_imm(br_imm),
    .br_issued(br_issued), .br_taken(br_taken), .br_target(br_target),
    .ld_addr(ld_addr), .is_load(is_load), .mem_write(mem_write),
    .st_data1(st_data1), .st_data2(st_data2), .st_addr1(st_addr1), .st_addr2(st_addr2),
    .hlt(hlt), .ld_data(ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [15:0] m_data [4];
  logic [3:0]  m_tag  [4];
  logic [15:0] m_imm  [2];
  logic [5:0]  m_ctrl [2];
  logic [2:0]  m_func [2];
  logic [3:0]  m_rob  [2];
  logic        m_spec [2];
  logic [15:0] m_pc2;
  logic        m_npc;
  logic [15:0] m_mem [1024];

  task automatic model_clear_disp();
    for (int k = 0; k < 4; k++) begin
      m_data[k] = 16'h0000;
      m_tag[k]  = 4'h0;
    end
    for (int k = 0; k < 2; k++) begin
      m_imm[k] = 16'h0000; m_ctrl[k] = 6'h00; m_func[k] = 3'h0;
      m_rob[k] = 4'h0;     m_spec[k] = 1'b0;
    end
    m_pc2 = 16'h0000;
    m_npc = 1'b0;
  endtask

  // Model state: dispatch snapshot and memory contents.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_clear_disp();
      for (int a = 0; a < 1024; a++) m_mem[a] = 16'h0000;
    end else begin
      if (flush) begin
        model_clear_disp();
      end else if (disp_write) begin
        m_tag[0] = tag_in1; m_tag[1] = tag_in2; m_tag[2] = tag_in3; m_tag[3] = tag_in4;
        m_data[0] = data_in1; m_data[1] = data_in2; m_data[2] = data_in3; m_data[3] = data_in4;
        m_imm[0] = imm_in1;   m_imm[1] = imm_in2;
        m_ctrl[0] = ctrl_in1; m_ctrl[1] = ctrl_in2;
        m_func[0] = func_in1; m_func[1] = func_in2;
        m_rob[0] = rob_in1;   m_rob[1] = rob_in2;
        m_spec[0] = spec_in1; m_spec[1] = spec_in2;
        m_pc2 = pc2_in;
        m_npc = npc_sel_in;
      end
      if (!hlt) begin
        if (mem_write[0]) m_mem[int'(st_addr1) % 1024] = st_data1;
        if (mem_write[1]) m_mem[int'(st_addr2) % 1024] = st_data2;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output with the model on each falling edge.
  always @(negedge clk) begin
    int exp_tgt;
    logic [15:0] exp_ld;
    chk("m_tag1", 32'(tag_out1), 32'(m_tag[0]));
    chk("m_tag2", 32'(tag_out2), 32'(m_tag[1]));
    chk("m_tag3", 32'(tag_out3), 32'(m_tag[2]));
    chk("m_tag4", 32'(tag_out4), 32'(m_tag[3]));
    chk("m_data1", 32'(data_out1), 32'(m_data[0]));
    chk("m_data2", 32'(data_out2), 32'(m_data[1]));
    chk("m_data3", 32'(data_out3), 32'(m_data[2]));
    chk("m_data4", 32'(data_out4), 32'(m_data[3]));
    chk("m_imm1", 32'(imm_out1), 32'(m_imm[0]));
    chk("m_imm2", 32'(imm_out2), 32'(m_imm[1]));
    chk("m_ctrl1", 32'(ctrl_out1), 32'(m_ctrl[0]));
    chk("m_ctrl2", 32'(ctrl_out2), 32'(m_ctrl[1]));
    chk("m_func1", 32'(func_out1), 32'(m_func[0]));
    chk("m_func2", 32'(func_out2), 32'(m_func[1]));
    chk("m_rob1", 32'(rob_out1), 32'(m_rob[0]));
    chk("m_rob2", 32'(rob_out2), 32'(m_rob[1]));
    chk("m_spec1", 32'(spec_out1), 32'(m_spec[0]));
    chk("m_spec2", 32'(spec_out2), 32'(m_spec[1]));
    chk("m_pc2", 32'(pc2_out), 32'(m_pc2));
    chk("m_npc", 32'(npc_sel_out), 32'(m_npc));
    exp_tgt = (int'(br_pc) + int'(br_imm)) % 65536;
    chk("m_br_taken", 32'(br_taken), (br_issued && (br_rs == br_rt)) ? 32'd1 : 32'd0);
    chk("m_br_target", 32'(br_target), 32'(exp_tgt));
    exp_ld = is_load ? m_mem[int'(ld_addr) % 1024] : 16'h0000;
    chk("m_ld_data", 32'(ld_data), 32'(exp_ld));
  end

  // ---------------- stimulus ----------------
  task automatic set_disp(input logic [15:0] b);
    tag_in1 = 4'd1 + b[15:12]; tag_in2 = 4'd2 + b[15:12];
    tag_in3 = 4'd3 + b[15:12]; tag_in4 = 4'd4 + b[15:12];
    data_in1 = b + 16'h0001; data_in2 = b + 16'h0002;
    data_in3 = b + 16'h0003; data_in4 = b + 16'h0004;
    imm_in1 = b + 16'h0011;  imm_in2 = b + 16'h0012;
    ctrl_in1 = 6'h01 + b[13:8]; ctrl_in2 = 6'h02 + b[13:8];
    func_in1 = 3'd1 ^ b[14:12]; func_in2 = 3'd2 ^ b[14:12];
    rob_in1 = 4'h9 ^ b[15:12];  rob_in2 = 4'hA ^ b[15:12];
    spec_in1 = 1'b1; spec_in2 = b[12];
    pc2_in = b + 16'h0020;
    npc_sel_in = ~b[13];
  endtask

  task automatic settle();
    @(negedge clk);
    #2;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    set_disp(16'h0000);
    flush = 1'b0; disp_write = 1'b0;
    br_rs = 16'h0000; br_rt = 16'h0001; br_pc = 16'h0000; br_imm = 16'h0000; br_issued = 1'b0;
    ld_addr = 16'h0000; is_load = 1'b0; mem_write = 2'b00;
    st_data1 = 16'h0000; st_data2 = 16'h0000; st_addr1 = 16'h0000; st_addr2 = 16'h0000;
    hlt = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("reset_ctrl1", 32'(ctrl_out1), 32'h0);
    chk("reset_data4", 32'(data_out4), 32'h0);
    rst = 1'b1;

    // load distinct dispatch values
    settle();
    set_disp(16'h1000); disp_write = 1'b1;
    after_edge();
    chk("load_data1", 32'(data_out1), 32'h1001);
    chk("load_imm2", 32'(imm_out2), 32'h1012);
    chk("load_pc2", 32'(pc2_out), 32'h1020);
    chk("load_tag4", 32'(tag_out4), 32'h5);
    chk("load_ctrl1", 32'(ctrl_out1), 32'h11);

    // stall: new inputs must not propagate
    settle();
    set_disp(16'h2000); disp_write = 1'b0;
    after_edge();
    chk("stall_data1", 32'(data_out1), 32'h1001);

    // flush wins over disp_write
    settle();
    flush = 1'b1; disp_write = 1'b1;
    after_edge();
    chk("flush_data1", 32'(data_out1), 32'h0);
    chk("flush_ctrl2", 32'(ctrl_out2), 32'h0);
    settle();
    flush = 1'b0;
    after_edge();
    chk("reload_data1", 32'(data_out1), 32'h2001);

    // dual write to one address: port 2 wins; same-cycle read sees old value
    settle();
    disp_write = 1'b0;
    mem_write = 2'b11; st_addr1 = 16'h0003; st_addr2 = 16'h0003;
    st_data1 = 16'h1234; st_data2 = 16'hBEEF;
    is_load = 1'b1; ld_addr = 16'h0003;
    #1;
    chk("same_cycle_old", 32'(ld_data), 32'h0);
    after_edge();
    chk("port2_wins", 32'(ld_data), 32'hBEEF);
    settle();
    mem_write = 2'b00; ld_addr = 16'h0403;
    #1;
    chk("addr_wrap_rd", 32'(ld_data), 32'hBEEF);

    // halt suppresses writes, reads continue
    settle();
    hlt = 1'b1; mem_write = 2'b11; st_data1 = 16'h5555; st_data2 = 16'h6666;
    after_edge();
    chk("hlt_no_write", 32'(ld_data), 32'hBEEF);
    settle();
    hlt = 1'b0; mem_write = 2'b00; is_load = 1'b0;
    #1;
    chk("no_load_zero", 32'(ld_data), 32'h0);

    // distinct addresses on both ports, upper store-address bits ignored
    settle();
    mem_write = 2'b11; st_addr1 = 16'hFC07; st_data1 = 16'hA5A5;
    st_addr2 = 16'h0008; st_data2 = 16'h5A5A;
    after_edge();
    settle();
    mem_write = 2'b00; is_load = 1'b1; ld_addr = 16'h0007;
    #1;
    chk("wrap_wr_port1", 32'(ld_data), 32'hA5A5);
    settle();
    ld_addr = 16'h0008;
    #1;
    chk("port2_write", 32'(ld_data), 32'h5A5A);

    // branch resolution
    settle();
    br_rs = 16'h0005; br_rt = 16'h0005; br_issued = 1'b1; br_pc = 16'h0010; br_imm = 16'h0004;
    #1;
    chk("br_taken_eq", 32'(br_taken), 32'h1);
    chk("br_target", 32'(br_target), 32'h0014);
    br_rt = 16'h0006;
    #1;
    chk("br_ne", 32'(br_taken), 32'h0);
    br_rt = 16'h0005; br_issued = 1'b0;
    #1;
    chk("br_not_issued", 32'(br_taken), 32'h0);
    br_pc = 16'hFFFE; br_imm = 16'h0004;
    #1;
    chk("br_target_wrap", 32'(br_target), 32'h0002);

    // reset mid-cycle: dispatch and memory clear at once, branch unaffected
    settle();
    set_disp(16'h3000); disp_write = 1'b1; ld_addr = 16'h0003;
    after_edge();
    chk("pre_rst_data1", 32'(data_out1), 32'h3001);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_data1", 32'(data_out1), 32'h0);
    chk("rst_async_pc2", 32'(pc2_out), 32'h0);
    chk("rst_async_tag1", 32'(tag_out1), 32'h0);
    chk("rst_mem_clear", 32'(ld_data), 32'h0);
    chk("rst_br_target", 32'(br_target), 32'h0002);
    // writes ignored during reset
    settle();
    mem_write = 2'b01; st_addr1 = 16'h0003; st_data1 = 16'h1111;
    after_edge();
    settle();
    rst = 1'b1; mem_write = 2'b00; disp_write = 1'b0;
    #1;
    chk("rst_write_ignored", 32'(ld_data), 32'h0);

    // mixed traffic, checked by the model each cycle
    for (int i = 0; i < 24; i++) begin
      settle();
      set_disp(16'($urandom));
      disp_write = 1'($urandom_range(0, 1));
      flush      = ($urandom_range(0, 7) == 0);
      mem_write  = 2'($urandom_range(0, 3));
      st_addr1   = {6'($urandom), 10'($urandom_range(0, 15))};
      st_addr2   = {6'($urandom), 10'($urandom_range(0, 15))};
      st_data1   = 16'($urandom);
      st_data2   = 16'($urandom);
      hlt        = ($urandom_range(0, 7) == 0);
      is_load    = 1'($urandom_range(0, 1));
      ld_addr    = {6'($urandom), 10'($urandom_range(0, 15))};
      br_rs      = 16'($urandom_range(0, 3));
      br_rt      = 16'($urandom_range(0, 3));
      br_issued  = 1'($urandom_range(0, 1));
      br_pc      = 16'($urandom);
      br_imm     = 16'($urandom);
    end
    settle();
    flush = 1'b0; mem_write = 2'b00; hlt = 1'b0;
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dispatch_branch_mem.md
DISPATCH_BRANCH_MEM -- requirements
Module: dispatch_branch_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: data, immediate, PC and address width.
REQ-002 SHALL have parameter MEM_DEPTH, default 1024: number of data-memory words; index is addr[9:0].
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have ports tag_in1..tag_in4, input, 4 each: ROB tags of rs1, rt1, rs2, rt2.
REQ-006 SHALL have ports data_in1..data_in4, input, 16 each: operand values of rs1, rt1, rs2, rt2.
REQ-007 SHALL have ports imm_in1/imm_in2 (16), ctrl_in1/ctrl_in2 (6), func_in1/func_in2 (3), rob_in1/rob_in2 (4), spec_in1/spec_in2 (1), all inputs: decoded fields of slots 1 and 2.
REQ-008 SHALL have ports pc2_in, input, 16 (PC+2), and npc_sel_in, input, 1 (predicted-taken bit).
REQ-009 SHALL have ports flush, input, 1, and disp_write, input, 1 (low means stall).
REQ-010 SHALL have an output `*_out` of the same width for every dispatch input in REQ-005..REQ-008.
REQ-011 SHALL have branch ports br_rs, br_rt, br_pc, br_imm (input, 16 each), br_issued (input, 1), br_taken (output, 1) and br_target (output, 16).
REQ-012 SHALL have memory ports ld_addr (input, 16), is_load (input, 1), mem_write (input, 2), st_data1, st_data2, st_addr1, st_addr2 (input, 16 each), hlt (input, 1) and ld_data (output, 16).

Function
REQ-013 Dispatch register SHALL, on each clk rising edge, clear when flush=1 (priority), else load all inputs when disp_write=1, else hold.
REQ-014 A clear SHALL set every dispatch output to 0, so ctrl=0 denotes a bubble.
REQ-015 Dispatch latency SHALL be exactly 1 cycle from input to *_out.
REQ-016 br_taken SHALL be combinational: 1 only when br_issued=1 and br_rs==br_rt, else 0.
REQ-017 br_target SHALL be combinational br_pc+br_imm, 16-bit modulo with no carry out, valid regardless of br_issued.
REQ-018 ld_data SHALL be combinational mem[ld_addr[9:0]] when is_load=1, else 0.
REQ-019 On a clk rising edge, mem_write[0]=1 SHALL write st_data1 to st_addr1[9:0] and mem_write[1]=1 SHALL write st_data2 to st_addr2[9:0].
REQ-020 When both write ports target the same address, port 2 SHALL win (younger in program order).
REQ-021 When hlt=1, all memory writes SHALL be suppressed; reads SHALL continue.
REQ-022 A read of an address written in the same cycle SHALL return the old value until the edge, and the new value after it.
REQ-023 Upper address bits [15:10] SHALL be ignored (wrap-around).

Reset
REQ-024 While rst=0, all dispatch outputs SHALL be 0, independent of clk.
REQ-025 While rst=0, all memory words SHALL be 0 and writes SHALL be ignored.
REQ-026 Reset asserted mid-operation SHALL discard pending dispatch contents immediately.
REQ-027 Branch outputs SHALL be combinational and unaffected by reset.

Structure
REQ-028 A shared package SHALL hold DATA_WIDTH, tag width 4, ctrl width 6, func width 3, MEM_DEPTH and the ctrl bit indices (5 load, 4 store, 3 R-type, 2 branch, 1 jump, 0 halt).
REQ-029 The design SHALL be built from three sub-modules instantiated by the top: dispatch_reg, branch_resolve and data_mem_2w.

Verification
REQ-030 Load all-distinct dispatch values with disp_write=1 -> outputs match after 1 edge; disp_write=0 with new inputs -> outputs unchanged.
REQ-031 flush=1 and disp_write=1 together -> all outputs 0 after the edge; rst=0 mid-cycle -> outputs 0 immediately.
REQ-032 br_rs=5, br_rt=5, br_issued=1, br_pc=0x0010, br_imm=0x0004 -> br_taken=1, br_target=0x0014; br_rt=6 -> br_taken=0; br_issued=0 -> br_taken=0.
REQ-033 br_pc=0xFFFE, br_imm=0x0004 -> br_target=0x0002.
REQ-034 Write 0x1234 to address 3 via port 1 and 0xBEEF to address 3 via port 2 in the same cycle -> load of address 3 returns 0xBEEF; load of address 0x0403 also returns 0xBEEF.
REQ-035 hlt=1 with mem_write=2'b11 -> memory contents unchanged; is_load=0 -> ld_data=0.
